// File: rtl/alu_issue_if.sv
// alu_issue_if: issue-stage handshake, ALU drive and writeback tracking bundle
interface alu_issue_if #(parameter int CNT_W = 16);
  logic in_valid;
  logic in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic wb_stall;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0] alu_ctrl;
  logic wb_valid;
  logic [4:0] wb_reg;
  logic illegal;
  logic divz_err;
  logic [CNT_W-1:0] issued_count;
  modport master (
    output in_valid, instr, rs_data, rt_data, wb_stall,
    input in_ready, alu_a, alu_b, alu_ctrl, wb_valid, wb_reg, illegal, divz_err, issued_count
  );
  modport slave (
    input in_valid, instr, rs_data, rt_data, wb_stall,
    output in_ready, alu_a, alu_b, alu_ctrl, wb_valid, wb_reg, illegal, divz_err, issued_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS-style decode/issue into a registered 3-bit-control ALU
// Optional ALU_ISSUE_DIVZERO_EN: divide by zero is squashed to a zero result and flagged.
module alu_issue_stage #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  alu_issue_if.slave io
);
  logic [5:0] op, fn;
  logic [31:0] imm_s, imm_z, b;
  logic [2:0] ctrl;
  logic [4:0] dest;
  logic legal, divz, fire, take;
  logic issue_valid;
  logic [4:0] issue_reg;
  logic [CNT_W-1:0] cnt;
  assign op = io.instr[31:26];
  assign fn = io.instr[5:0];
  assign imm_s = {{16{io.instr[15]}}, io.instr[15:0]};
  assign imm_z = {16'h0, io.instr[15:0]};
  assign io.in_ready = rst_n & ~io.wb_stall;
  assign fire = io.in_valid & io.in_ready;
  assign take = fire & legal;
  assign io.issued_count = cnt;
  always_comb begin
    legal = 1'b1;
    ctrl = 3'b000;
    b = imm_s;
    dest = io.instr[20:16];
    if (op == 6'b000000) begin
      b = io.rt_data;
      dest = io.instr[15:11];
      case (fn)
        6'b100000: ctrl = 3'b000;
        6'b100010: ctrl = 3'b001;
        6'b100100: ctrl = 3'b010;
        6'b100101: ctrl = 3'b011;
        6'b101010: ctrl = 3'b100;
        6'b011000: ctrl = 3'b101;
        6'b011010: ctrl = 3'b110;
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'b001000: ctrl = 3'b000;
        6'b001010: ctrl = 3'b100;
        6'b001100: begin ctrl = 3'b010; b = imm_z; end
        6'b001101: begin ctrl = 3'b011; b = imm_z; end
        default: legal = 1'b0;
      endcase
    end
  end
`ifdef ALU_ISSUE_DIVZERO_EN
  assign divz = legal & (ctrl == 3'b110) & ~|b;
`else
  assign divz = 1'b0;
`endif
  // A stall freezes every register, pulses included, so the ALU keeps recomputing the same result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.alu_a <= '0;
      io.alu_b <= '0;
      io.alu_ctrl <= '0;
      issue_valid <= 1'b0;
      issue_reg <= '0;
      io.wb_valid <= 1'b0;
      io.wb_reg <= '0;
      io.illegal <= 1'b0;
      io.divz_err <= 1'b0;
      cnt <= '0;
    end else if (!io.wb_stall) begin
      issue_valid <= take & (dest != 5'd0) & ~divz;
      issue_reg <= take ? dest : issue_reg;
      io.wb_valid <= issue_valid;
      io.wb_reg <= issue_reg;
      io.illegal <= fire & ~legal;
      io.divz_err <= take & divz;
      io.alu_a <= take ? io.rs_data : io.alu_a;
      io.alu_b <= take ? b : io.alu_b;
      io.alu_ctrl <= take ? (divz ? 3'b010 : ctrl) : io.alu_ctrl;
      cnt <= cnt + CNT_W'(take);
    end
  end
endmodule
